// File: rtl/taxi_eth_mac_pkg.sv
// Shared Ethernet MAC constants: pause quantum size and timer widths.
package taxi_eth_mac_pkg;

  // One pause quantum is 512 bit times.
  localparam int PAUSE_QUANTUM_BITS = 512;
  // Default width of one pause quanta value.
  localparam int PAUSE_QUANTA_W     = 16;
  // Bit-time accumulator width, enough to hold 0..PAUSE_QUANTUM_BITS-1.
  localparam int PAUSE_ACC_W        = $clog2(PAUSE_QUANTUM_BITS);
  // Step width: accumulator plus one carry bit, so acc+step never overflows.
  localparam int PAUSE_STEP_W       = PAUSE_ACC_W + 1;

  // Bit times carried by one enabled beat.
  function automatic logic [PAUSE_STEP_W-1:0] pause_step(input logic mii, input int data_w);
    return mii ? PAUSE_STEP_W'(4) : PAUSE_STEP_W'(data_w);
  endfunction

endpackage

// File: rtl/taxi_mac_pause_timer_ch.sv
// One pause channel: quanta counter Q plus 512-bit-time accumulator B.
// IDLE is Q == 0, PAUSED is Q != 0; all outputs are registered.
module taxi_mac_pause_timer_ch
  import taxi_eth_mac_pkg::*;
#(
  parameter int QUANTA_W = PAUSE_QUANTA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ch_en,
  input  logic                    load,
  input  logic [QUANTA_W-1:0]     load_quanta,
  input  logic                    beat,
  input  logic [PAUSE_STEP_W-1:0] step,
  input  logic                    ack,
  output logic                    pause_req,
  output logic                    zero_evt,
  output logic                    paused_evt
);

  logic [QUANTA_W-1:0]     q_q;
  logic [PAUSE_ACC_W-1:0]  b_q;
  logic [PAUSE_STEP_W-1:0] sum;
  logic                    wrap;

  // B+step fits in PAUSE_STEP_W bits; the top bit is the quantum carry and the
  // low bits are already B+step-512 when it is set.
  assign sum  = {1'b0, b_q} + step;
  assign wrap = sum[PAUSE_STEP_W-1];

  // Counter update: disable beats load, load beats decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q        <= '0;
      b_q        <= '0;
      pause_req  <= 1'b0;
      zero_evt   <= 1'b0;
      paused_evt <= 1'b0;
    end else begin
      zero_evt   <= 1'b0;
      paused_evt <= 1'b0;
      if (!ch_en) begin
        q_q       <= '0;
        b_q       <= '0;
        pause_req <= 1'b0;
      end else if (load) begin
        q_q       <= load_quanta;
        b_q       <= '0;
        pause_req <= (load_quanta != '0);
      end else if (beat && (q_q != '0)) begin
        b_q <= sum[PAUSE_ACC_W-1:0];
        if (wrap) begin
          q_q        <= q_q - QUANTA_W'(1);
          pause_req  <= (q_q != QUANTA_W'(1));
          zero_evt   <= (q_q == QUANTA_W'(1));
          paused_evt <= ack;
        end
      end
    end
  end

endmodule

// File: rtl/taxi_mac_pause_timer.sv
// Multi-channel MAC pause timer (LFC with CH_CNT=1, PFC with CH_CNT=8).
// The top only selects the per-beat bit-time step and fans loads out.
module taxi_mac_pause_timer
  import taxi_eth_mac_pkg::*;
#(
  parameter int CH_CNT   = 8,
  parameter int DATA_W   = 8,
  parameter int QUANTA_W = PAUSE_QUANTA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_enable,
  input  logic                         mii_select,
  input  logic [CH_CNT-1:0]            cfg_ch_en,
  input  logic                         s_load_valid,
  output logic                         s_load_ready,
  input  logic [CH_CNT-1:0]            s_load_mask,
  input  logic [CH_CNT*QUANTA_W-1:0]   s_load_quanta,
  input  logic [CH_CNT-1:0]            pause_ack,
  output logic [CH_CNT-1:0]            pause_req,
  output logic [CH_CNT-1:0]            timer_zero_evt,
  output logic [CH_CNT-1:0]            stat_paused
);

  logic [PAUSE_STEP_W-1:0] step;
  logic                    load_xfer;

  // Always ready outside reset; a load is a plain valid/ready handshake.
  assign s_load_ready = !rst;
  assign load_xfer    = s_load_valid && s_load_ready;
  assign step         = pause_step(mii_select, DATA_W);

  for (genvar g = 0; g < CH_CNT; g++) begin : g_ch
    taxi_mac_pause_timer_ch #(
      .QUANTA_W (QUANTA_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .ch_en       (cfg_ch_en[g]),
      .load        (load_xfer && s_load_mask[g]),
      .load_quanta (s_load_quanta[g*QUANTA_W +: QUANTA_W]),
      .beat        (clk_enable),
      .step        (step),
      .ack         (pause_ack[g]),
      .pause_req   (pause_req[g]),
      .zero_evt    (timer_zero_evt[g]),
      .paused_evt  (stat_paused[g])
    );
  end

endmodule
